// File: rtl/sevenseg_scan_driver.sv
// Multiplexed 8-digit common-anode 7-segment driver with per-slot blanking.
// Define SEVENSEG_DP_EN to light decimal points on digits 2 and 4.
module sevenseg_scan_driver #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] sevenseg,
  input  logic [7:0]  digital_enable,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIGIT_TICKS);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] SH_LAST = CW'(DIGIT_TICKS - BLANK_TICKS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [31:0]     r_snap_seg;
  logic [7:0]      r_snap_en;
  logic [31:0]     w_snap_seg_nxt;
  logic [7:0]      w_snap_en_nxt;
  logic            w_load;
  logic            w_on;
  logic [3:0]      w_nib;
  logic [7:0]      w_an_nxt;
  logic [6:0]      w_seg_nxt;
  logic            w_ft_nxt;
  logic [7:0]      r_an_n;
  logic [6:0]      r_seg_n;
  logic            r_ft;

  function automatic logic [6:0] f_dec(input logic [3:0] v);
    unique case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      4'hF: return 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + CW'(1);
    unique case (r_state)
      BLANK: begin
        if (r_cnt == BL_LAST) begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (r_cnt == SH_LAST) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
    endcase
  end

  // Outputs are registered from next-state values so they align with state.
  assign w_load = (r_state == BLANK) && (r_idx == 3'd0);
  assign w_snap_seg_nxt = w_load ? sevenseg : r_snap_seg;
  assign w_snap_en_nxt  = w_load ? digital_enable : r_snap_en;
  assign w_nib = w_snap_seg_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_on  = (w_state_nxt == SHOW) && w_snap_en_nxt[w_idx_nxt];
  assign w_an_nxt  = w_on ? ~(8'b1 << w_idx_nxt) : 8'hFF;
  assign w_seg_nxt = w_on ? f_dec(w_nib) : 7'h7F;
  assign w_ft_nxt  = (w_state_nxt == SHOW) && (w_idx_nxt == 3'd7)
                  && (w_cnt_nxt == SH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_seg <= '0;
      r_snap_en  <= '0;
      r_an_n     <= 8'hFF;
      r_seg_n    <= 7'h7F;
      r_ft       <= 1'b0;
    end else begin
      r_snap_seg <= w_snap_seg_nxt;
      r_snap_en  <= w_snap_en_nxt;
      r_an_n     <= w_an_nxt;
      r_seg_n    <= w_seg_nxt;
      r_ft       <= w_ft_nxt;
    end
  end

  assign an_n       = r_an_n;
  assign seg_n      = r_seg_n;
  assign frame_tick = r_ft;

`ifdef SEVENSEG_DP_EN
  logic r_dp_n;
  logic w_dp_nxt;

  assign w_dp_nxt = ~(w_on && ((w_idx_nxt == 3'd2) || (w_idx_nxt == 3'd4)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dp_n <= 1'b1;
    else        r_dp_n <= w_dp_nxt;
  end

  assign dp_n = r_dp_n;
`else
  assign dp_n = 1'b1;
`endif

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: frame-position model plus directed checks.
module tb_sevenseg_scan_driver;

  localparam int DT = 10;
  localparam int BT = 2;
  localparam int FR = 8 * DT;
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] sevenseg = '0;
  logic [7:0]  digital_enable = '0;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .DIGIT_TICKS(DT),
    .BLANK_TICKS(BT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sevenseg      (sevenseg),
    .digital_enable(digital_enable),
    .an_n          (an_n),
    .seg_n         (seg_n),
    .dp_n          (dp_n),
    .frame_tick    (frame_tick)
  );

  // Model: position within the frame; inputs captured in the first BT cycles.
  int          m_pos;
  logic [31:0] m_seg;
  logic [7:0]  m_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0;
      m_seg <= '0;
      m_en  <= '0;
    end else begin
      if (m_pos < BT) begin
        m_seg <= sevenseg;
        m_en  <= digital_enable;
      end
      m_pos <= (m_pos + 1) % FR;
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t pos=%0d)",
               nm, got, exp, $time, m_pos);
    end
  endtask

  task automatic wait_pos(int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_pos != p && n < 200);
    if (m_pos != p) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pos: timeout waiting for %0d", p);
    end
  endtask

  int         e_slot;
  int         e_off;
  logic       e_on;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_ft;
  logic [3:0] kk;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          e_slot = m_pos / DT;
          e_off  = m_pos % DT;
          e_on   = (e_off >= BT) && m_en[e_slot];
          e_an   = e_on ? ~(8'h01 << e_slot) : 8'hFF;
          e_seg  = e_on ? SEG[m_seg[e_slot*4 +: 4]] : 7'h7F;
`ifdef SEVENSEG_DP_EN
          e_dp   = !(e_on && (e_slot == 2 || e_slot == 4));
`else
          e_dp   = 1'b1;
`endif
          e_ft   = (m_pos == FR - 1);
          chk("model_an_n", an_n, e_an);
          chk("model_seg_n", seg_n, e_seg);
          chk("model_dp_n", dp_n, e_dp);
          chk("model_frame_tick", frame_tick, e_ft);
        end
      end
    join_none

    // Asynchronous reset between clock edges
    #7 rst_n = 1'b0;
    #1;
    chk("rst_an_n", an_n, 8'hFF);
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_frame_tick", frame_tick, 1'b0);
    sevenseg = 32'h0000_0123;
    digital_enable = 8'h07;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rel_1cyc_an_n", an_n, 8'hFF);
    @(posedge clk);
    #1 chk("rel_2cyc_an_n", an_n, 8'hFE);
    chk("rel_2cyc_seg_n", seg_n, 7'h30);

    // Basic scan
    wait_pos(15);
    chk("scan_s1_an", an_n, 8'hFD);
    chk("scan_s1_seg", seg_n, 7'h24);
    wait_pos(25);
    chk("scan_s2_an", an_n, 8'hFB);
    chk("scan_s2_seg", seg_n, 7'h79);
    wait_pos(35);
    chk("scan_s3_an", an_n, 8'hFF);
    wait_pos(78);
    chk("scan_ft_78", frame_tick, 1'b0);
    wait_pos(79);
    chk("scan_ft_79", frame_tick, 1'b1);
    wait_pos(9);
    chk("scan_s0_last_an", an_n, 8'hFE);

    // Tearing: change mid-frame, must not show until next frame
    sevenseg = 32'h0;
    digital_enable = 8'hFF;
    wait_pos(79);
    wait_pos(33);
    sevenseg = 32'h1111_1111;
    wait_pos(45);
    chk("tear_s4_seg", seg_n, 7'h40);
    wait_pos(75);
    chk("tear_s7_seg", seg_n, 7'h40);
    wait_pos(5);
    chk("tear_next_s0_seg", seg_n, 7'h79);
    wait_pos(72);
    chk("tear_next_s7_seg", seg_n, 7'h79);

    // Decoder sweep
    for (int k = 0; k < 16; k++) begin
      kk = 4'(k);
      sevenseg = {8{kk}};
      wait_pos(5);
      chk("sweep_seg", seg_n, 32'(SEG[k]));
      wait_pos(72);
    end

    // Reset during slot 5 SHOW
    wait_pos(55);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_an_n", an_n, 8'hFF);
    chk("midrst_seg_n", seg_n, 7'h7F);
    chk("midrst_dp_n", dp_n, 1'b1);
    chk("midrst_frame_tick", frame_tick, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("midrst_1cyc_an", an_n, 8'hFF);
    @(posedge clk);
    #1 chk("midrst_2cyc_an", an_n, 8'hFE);
    chk("midrst_2cyc_seg", seg_n, 7'h0E);

`ifdef SEVENSEG_DP_EN
    wait_pos(25);
    chk("dp_s2_on", dp_n, 1'b0);
    wait_pos(35);
    chk("dp_s3_off", dp_n, 1'b1);
    wait_pos(45);
    chk("dp_s4_on", dp_n, 1'b0);
    wait_pos(72);
    digital_enable = 8'hEB;
    wait_pos(25);
    chk("dp_eb_s2", dp_n, 1'b1);
    wait_pos(45);
    chk("dp_eb_s4", dp_n, 1'b1);
`endif

    wait_pos(20);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
